// File: rtl/freq_display_driver.sv
// rtl/freq_display_driver.sv - binary-to-BCD converter and multiplexed 7-segment driver
//
// Converts freq_in (Hz) to 8 packed BCD digits with a sequential double-dabble
// converter (32 shift cycles), then scans the digits onto a common-anode
// 7-segment display.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
//
// Ports:
//   clk      system clock
//   rst_n    synchronous reset, active-high
//   freq_in  32-bit binary frequency
//   seg      {dp,g,f,e,d,c,b,a}, active-low
//   an       digit enables, active-low, an[0] = units
//   bcd_out  packed BCD of last completed conversion, [3:0] = units
//   busy     conversion in progress
//   ovf      last latched value exceeds 99_999_999
module freq_display_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 10000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         freq_in,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                busy,
  output logic                ovf
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] shreg;
  logic [31:0] last_val;
  logic [39:0] scratch;
  logic [39:0] scratch_adj;
  logic [4:0]  cnt;
  logic        force_flag;
  logic        start;

  logic [SCW-1:0] scan_cnt;
  logic [IW-1:0]  digit_idx;
  logic [3:0]     nibble;
  logic [7:0]     seg_next;

  assign start = force_flag || (freq_in != last_val);

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 10; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath
  always_ff @(posedge clk) begin
    if (rst_n) begin
      shreg      <= '0;
      last_val   <= '0;
      scratch    <= '0;
      cnt        <= '0;
      force_flag <= 1'b1;
      bcd_out    <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg      <= freq_in;
            last_val   <= freq_in;
            force_flag <= 1'b0;
            scratch    <= '0;
            cnt        <= '0;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[38:0], shreg[31]};
          shreg   <= {shreg[30:0], 1'b0};
          cnt     <= cnt + 5'd1;
        end
        DONE: begin
          // bcd_out and ovf change together, only here
          bcd_out <= scratch[4*DIGITS-1:0];
          ovf     <= (scratch[39:32] != 8'd0) || (last_val > 32'd99_999_999);
        end
        default: ;
      endcase
    end
  end

  // Digit scan counter and index
  always_ff @(posedge clk) begin
    if (rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign nibble = bcd_out[4*digit_idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more significant digit are zero;
  // the units digit always shows.
  logic upper_nz;
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) >= digit_idx && bcd_out[4*i +: 4] != 4'd0) upper_nz = 1'b1;
    end
  end
`endif

  always_comb begin
    case (nibble)
      4'd0:    seg_next = 8'hC0;
      4'd1:    seg_next = 8'hF9;
      4'd2:    seg_next = 8'hA4;
      4'd3:    seg_next = 8'hB0;
      4'd4:    seg_next = 8'h99;
      4'd5:    seg_next = 8'h92;
      4'd6:    seg_next = 8'h82;
      4'd7:    seg_next = 8'hF8;
      4'd8:    seg_next = 8'h80;
      4'd9:    seg_next = 8'h90;
      default: seg_next = 8'hFF;
    endcase
    if (ovf) seg_next = 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
    else if (digit_idx != '0 && !upper_nz) seg_next = 8'hFF;
`endif
  end

  // seg and an are registered from the same index so they switch together
  always_ff @(posedge clk) begin
    if (rst_n) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= ~(DIGITS'(1) << digit_idx);
    end
  end

endmodule

// File: tb/tb_freq_display_driver.sv
// tb/tb_freq_display_driver.sv - scoreboard testbench for freq_display_driver
module tb_freq_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] freq_in;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [31:0] bcd_out;
  logic        busy;
  logic        ovf;

  freq_display_driver #(.DIGITS(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .freq_in(freq_in), .seg(seg), .an(an),
    .bcd_out(bcd_out), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rst_q = 1'b1;
  logic prev_busy = 1'b0;
  longint cur_val;
  bit     cur_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r;
    longint t;
    t = v % 100000000;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_seg(input longint v, input bit ov, input int idx);
    logic [7:0] tbl [10];
    longint p;
    longint t;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    t = v % 100000000;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (ov) return 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && t < p) return 8'hFF;
`endif
    return tbl[(t / p) % 10];
  endfunction

  task automatic push(input longint v);
    exp_t e;
    e.bcd = to_bcd(v);
    e.ovf = (v > 99999999);
    sb.push_back(e);
    cur_val = v;
    cur_ovf = (v > 99999999);
  endtask

  always @(posedge clk) rst_q <= rst_n;

  // Compare a completed conversion whenever busy falls outside of reset
  always @(negedge clk) begin
    exp_t e;
    if (rst_q === 1'b1) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy === 1'b1 && busy === 1'b0) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("bcd_out", 64'(bcd_out), 64'(e.bcd));
          check("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_seg", 64'(seg), 64'hFF);
    check("rst_an", 64'(an), 64'hFF);
    check("rst_bcd", 64'(bcd_out), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ovf", 64'(ovf), 64'h0);
  endtask

  // Latency after reset release: latch at edge 1, publish at edge 34
  task automatic check_latency(input longint v);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1)  check("busy_c1", 64'(busy), 64'd1);
      if (k == 33) check("busy_c33", 64'(busy), 64'd1);
      if (k == 33) check("bcd_before", 64'(bcd_out), 64'h0);
      if (k == 34) check("bcd_lat34", 64'(bcd_out), 64'(to_bcd(v)));
      if (k == 34) check("busy_c34", 64'(busy), 64'd0);
    end
  endtask

  // Observe 32 scan cycles: an rotates one position every 4 clocks and seg
  // matches the digit currently enabled.
  task automatic scan_check(input string tag);
    logic [7:0] prev_an;
    int changes = 0;
    int idx;
    prev_an = an;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      idx = 0;
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) idx = i;
      if ($countones(~an) != 1) check({tag, "_an_onehot"}, 64'(an), 64'(~(8'd1 << idx)));
      check({tag, "_seg"}, 64'(seg), 64'(exp_seg(cur_val, cur_ovf, idx)));
      if (an != prev_an) begin
        changes++;
        check({tag, "_an_step"}, 64'(an), 64'({prev_an[6:0], prev_an[7]}));
      end
      prev_an = an;
    end
    check({tag, "_an_changes"}, 64'(changes), 64'd8);
  endtask

  initial begin
    rst_n   = 1'b1;
    freq_in = 32'd4882;
    repeat (2) @(negedge clk);
    check_reset_vals();

    // 1: forced conversion after reset, exact latency
    push(4882);
    rst_n = 1'b0;
    check_latency(4882);
    wait_done();

    // 2: largest displayable value, then overflow
    freq_in = 32'd99_999_999;
    push(99999999);
    wait_done();
    freq_in = 32'd100_000_000;
    push(100000000);
    wait_done();
    scan_check("ovf");

    // 3: input changes mid-conversion, restart afterwards
    freq_in = 32'd1234;
    push(1234);
    repeat (11) @(negedge clk);
    freq_in = 32'd5678;
    push(5678);
    wait_done();
    scan_check("s5678");

    // 4/5: scan order and leading-digit handling
    freq_in = 32'd4882;
    push(4882);
    wait_done();
    scan_check("s4882");
    freq_in = 32'd0;
    push(0);
    wait_done();
    scan_check("s0");
    freq_in = 32'd90_705_310;
    push(90705310);
    wait_done();
    scan_check("s9070");

    // 6: reset in the middle of a conversion
    freq_in = 32'd7777;
    push(7777);
    repeat (12) @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals();
    push(7777);
    rst_n = 1'b0;
    check_latency(7777);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
